// File: rtl/gray_code_pkg.sv
// Shared Gray-code helpers and converter mode encodings.
// The helpers run at a fixed 32-bit width and mask the operand down to the requested width.
package gray_code_pkg;

    localparam logic CONV_B2G = 1'b0;
    localparam logic CONV_G2B = 1'b1;
    localparam int unsigned MAX_W = 32;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
        if (w >= MAX_W)
            return '1;
        return (32'd1 << w) - 32'd1;
    endfunction

    // Bits above w are cleared first, so the top active bit passes through unchanged.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b, input int unsigned w);
        logic [MAX_W-1:0] bm;
        logic [MAX_W-1:0] g;
        bm = b & width_mask(w);
        for (int i = 0; i < MAX_W - 1; i++)
            g[i] = bm[i] ^ bm[i+1];
        g[MAX_W-1] = bm[MAX_W-1];
        return g;
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g, input int unsigned w);
        logic [MAX_W-1:0] gm;
        logic [MAX_W-1:0] b;
        gm = g & width_mask(w);
        b[MAX_W-1] = gm[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--)
            b[i] = b[i+1] ^ gm[i];
        return b;
    endfunction

endpackage

// File: rtl/gray_code_engine_conv.sv
// Registered binary<->Gray converter.
// The valid bit follows the input every cycle; the data register loads only on a qualified input.
module gray_conv_stage
    import gray_code_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (valid_in) begin
            if (mode == CONV_G2B)
                data_d = WIDTH'(gray2bin(32'(data_in), WIDTH));
            else
                data_d = WIDTH'(bin2gray(32'(data_in), WIDTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= valid_in;
            data_q <= data_d;
        end
    end

    assign valid_out = vld_q;
    assign data_out  = data_q;

endmodule

// File: rtl/gray_code_engine.sv
// Up/down binary counter with a Gray-coded copy registered on the same edge,
// alongside an independent one-cycle binary<->Gray converter.
module gray_code_engine
    import gray_code_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             cnt_up,
    input  logic             cnt_load,
    input  logic [WIDTH-1:0] cnt_load_val,
    output logic [WIDTH-1:0] cnt_bin,
    output logic [WIDTH-1:0] cnt_gray,
    output logic             cnt_wrap,
    input  logic             conv_valid_in,
    input  logic             conv_mode,
    input  logic [WIDTH-1:0] conv_data_in,
    output logic             conv_valid_out,
    output logic [WIDTH-1:0] conv_data_out
);

    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(32'(RESET_VAL), WIDTH));
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    // Gray is derived from the next binary value, so both registers always agree.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (cnt_load) begin
            bin_d = cnt_load_val;
        end else if (cnt_en) begin
            if (cnt_up) begin
                bin_d  = bin_q + ONE;
                wrap_d = &bin_q;
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = ~|bin_q;
            end
        end
        gray_d = WIDTH'(bin2gray(32'(bin_d), WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_bin  = bin_q;
    assign cnt_gray = gray_q;
    assign cnt_wrap = wrap_q;

    gray_conv_stage #(.WIDTH(WIDTH)) u_conv (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (conv_valid_in),
        .mode      (conv_mode),
        .data_in   (conv_data_in),
        .valid_out (conv_valid_out),
        .data_out  (conv_data_out)
    );

endmodule

// File: tb/tb_gray_code_engine.sv
// Directed bench: a 4-bit engine driven from a vector table plus hand-written
// reset and converter sequences, and an 8-bit engine for the wide wrap case.
module tb_gray_code_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       en4 = 0, up4 = 0, ld4 = 0, cvi4 = 0, cm4 = 0;
    logic [3:0] lv4 = '0, cdi4 = '0;
    logic [3:0] bin4, gray4, cdo4;
    logic       wrap4, cvo4;

    logic       en8 = 0, up8 = 0, ld8 = 0, cvi8 = 0, cm8 = 0;
    logic [7:0] lv8 = '0, cdi8 = '0;
    logic [7:0] bin8, gray8, cdo8;
    logic       wrap8, cvo8;

    gray_code_engine #(.WIDTH(4), .RESET_VAL(0)) dut4 (
        .clk(clk), .rst(rst), .cnt_en(en4), .cnt_up(up4), .cnt_load(ld4),
        .cnt_load_val(lv4), .cnt_bin(bin4), .cnt_gray(gray4), .cnt_wrap(wrap4),
        .conv_valid_in(cvi4), .conv_mode(cm4), .conv_data_in(cdi4),
        .conv_valid_out(cvo4), .conv_data_out(cdo4)
    );

    gray_code_engine #(.WIDTH(8), .RESET_VAL(32'hFE)) dut8 (
        .clk(clk), .rst(rst), .cnt_en(en8), .cnt_up(up8), .cnt_load(ld8),
        .cnt_load_val(lv8), .cnt_bin(bin8), .cnt_gray(gray8), .cnt_wrap(wrap8),
        .conv_valid_in(cvi8), .conv_mode(cm8), .conv_data_in(cdi8),
        .conv_valid_out(cvo8), .conv_data_out(cdo8)
    );

    typedef struct packed {
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] lval;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrap;
    } cnt_vec_t;

    cnt_vec_t   vec [22];
    logic [3:0] gtab [16];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] prev_gray;

        gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

        //            en up ld lval  bin   gray  wrap
        vec[0]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 1'b0};
        vec[1]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h2, 4'h3, 1'b0};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h3, 4'h2, 1'b0};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h4, 4'h6, 1'b0};
        vec[4]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h5, 4'h7, 1'b0};
        vec[5]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h6, 4'h5, 1'b0};
        vec[6]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h7, 4'h4, 1'b0};
        vec[7]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h8, 4'hC, 1'b0};
        vec[8]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h9, 4'hD, 1'b0};
        vec[9]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hA, 4'hF, 1'b0};
        vec[10] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hB, 4'hE, 1'b0};
        vec[11] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hC, 4'hA, 1'b0};
        vec[12] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hD, 4'hB, 1'b0};
        vec[13] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hE, 4'h9, 1'b0};
        vec[14] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 4'h8, 1'b0};
        vec[15] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1};
        vec[16] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 1'b0};
        vec[17] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[18] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'h8, 1'b1};
        vec[19] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 4'h9, 1'b0};
        vec[20] = '{1'b1, 1'b1, 1'b1, 4'h6, 4'h6, 4'h5, 1'b0};
        vec[21] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h6, 4'h5, 1'b0};

        // Reset state of both instances.
        tick();
        tick();
        check("rst4_bin",  32'(bin4),  32'h0);
        check("rst4_gray", 32'(gray4), 32'h0);
        check("rst4_wrap", 32'(wrap4), 32'h0);
        check("rst4_cvo",  32'(cvo4),  32'h0);
        check("rst4_cdo",  32'(cdo4),  32'h0);
        check("rst8_bin",  32'(bin8),  32'hFE);
        check("rst8_gray", 32'(gray8), 32'h81);
        rst = 1'b0;

        // Counter vector table.
        prev_gray = 4'h0;
        for (int i = 0; i < 22; i++) begin
            en4 = vec[i].en;
            up4 = vec[i].up;
            ld4 = vec[i].load;
            lv4 = vec[i].lval;
            tick();
            check($sformatf("vec%0d_bin", i),  32'(bin4),  32'(vec[i].bin));
            check($sformatf("vec%0d_gray", i), 32'(gray4), 32'(vec[i].gray));
            check($sformatf("vec%0d_wrap", i), 32'(wrap4), 32'(vec[i].wrap));
            if (vec[i].en && !vec[i].load)
                check($sformatf("vec%0d_gray_1bit", i), 32'($countones(prev_gray ^ gray4)), 32'd1);
            prev_gray = gray4;
        end
        en4 = 0; up4 = 0; ld4 = 0;

        // Converter sweep, back-to-back in both modes.
        for (int i = 0; i < 16; i++) begin
            cvi4 = 1'b1; cm4 = 1'b0; cdi4 = 4'(i);
            tick();
            check($sformatf("b2g_%0d_vld", i),  32'(cvo4), 32'h1);
            check($sformatf("b2g_%0d_data", i), 32'(cdo4), 32'(gtab[i]));
        end
        for (int i = 0; i < 16; i++) begin
            cvi4 = 1'b1; cm4 = 1'b1; cdi4 = gtab[i];
            tick();
            check($sformatf("g2b_%0d_vld", i),  32'(cvo4), 32'h1);
            check($sformatf("g2b_%0d_data", i), 32'(cdo4), 32'(i));
        end
        cvi4 = 1'b0; cm4 = 1'b0; cdi4 = 4'h3;
        tick();
        check("conv_idle_vld",  32'(cvo4), 32'h0);
        check("conv_idle_hold", 32'(cdo4), 32'hF);
        tick();
        check("conv_idle_hold2", 32'(cdo4), 32'hF);

        // Asynchronous reset while counting at 7 with a conversion in flight.
        ld4 = 1'b1; lv4 = 4'h7;
        tick();
        check("mid_load_bin", 32'(bin4), 32'h7);
        ld4 = 1'b0; en4 = 1'b1; up4 = 1'b1;
        cvi4 = 1'b1; cm4 = 1'b0; cdi4 = 4'h5;
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_bin",  32'(bin4),  32'h0);
        check("mid_rst_gray", 32'(gray4), 32'h0);
        check("mid_rst_wrap", 32'(wrap4), 32'h0);
        check("mid_rst_cvo",  32'(cvo4),  32'h0);
        check("mid_rst_cdo",  32'(cdo4),  32'h0);
        check("mid_rst_bin8", 32'(bin8),  32'hFE);
        tick();
        check("mid_rst_hold_bin", 32'(bin4), 32'h0);
        check("mid_rst_hold_cvo", 32'(cvo4), 32'h0);
        rst = 1'b0;
        cvi4 = 1'b0;
        tick();
        check("post_rst_bin",  32'(bin4),  32'h1);
        check("post_rst_gray", 32'(gray4), 32'h1);
        check("post_rst_cvo",  32'(cvo4),  32'h0);
        en4 = 1'b0;

        // Wide instance: wrap from 8'hFE and Gray->binary of 8'h80.
        en8 = 1'b1; up8 = 1'b1;
        cvi8 = 1'b1; cm8 = 1'b1; cdi8 = 8'h80;
        tick();
        check("w8_bin_ff",   32'(bin8),  32'hFF);
        check("w8_gray_80",  32'(gray8), 32'h80);
        check("w8_wrap0",    32'(wrap8), 32'h0);
        check("w8_g2b_vld",  32'(cvo8),  32'h1);
        check("w8_g2b_data", 32'(cdo8),  32'hFF);
        cvi8 = 1'b0;
        tick();
        check("w8_bin_00",   32'(bin8),  32'h00);
        check("w8_gray_00",  32'(gray8), 32'h00);
        check("w8_wrap1",    32'(wrap8), 32'h1);
        check("w8_conv_idle", 32'(cvo8), 32'h0);
        en8 = 1'b0;
        tick();
        check("w8_hold_wrap0", 32'(wrap8), 32'h0);
        check("w8_hold_bin",   32'(bin8),  32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_code_engine.md
Name: gray_code_engine

Overview:
Parametrised Gray-code block: a registered up/down Gray counter with synchronous load, plus an independent 1-cycle pipelined binary<->Gray converter with per-transaction mode select.
It succeeds the fixed 4-bit combinational binary-to-Gray converter.
Used for CDC pointer generation (async FIFO pointers) and for code conversion in datapaths.
All outputs are registered.

Parameters:
WIDTH, 4, code width in bits; legal range 2..32.
RESET_VAL, 0, binary counter value after reset; must be < 2**WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
cnt_en  input  1  counter advance enable.
cnt_up  input  1  direction: 1 = increment, 0 = decrement; sampled only when cnt_en=1.
cnt_load  input  1  synchronous load strobe.
cnt_load_val  input  WIDTH  binary value to load.
cnt_bin  output  WIDTH  registered binary count.
cnt_gray  output  WIDTH  registered Gray code of cnt_bin.
cnt_wrap  output  1  one-cycle pulse when the count wraps.
conv_valid_in  input  1  converter input qualifier.
conv_mode  input  1  0 = binary->Gray, 1 = Gray->binary.
conv_data_in  input  WIDTH  converter operand.
conv_valid_out  output  1  converter result qualifier.
conv_data_out  output  WIDTH  converter result.

Behaviour:
- Reset (async assert; release synchronous to clk):
  - cnt_bin = RESET_VAL
  - cnt_gray = RESET_VAL ^ (RESET_VAL >> 1)
  - cnt_wrap = 0, conv_valid_out = 0, conv_data_out = 0
- Reset asserted mid-operation overrides everything immediately. No partial state survives. An in-flight conversion is dropped (conv_valid_out = 0).
- Counter priority per rising edge: cnt_load > cnt_en > hold.
  - cnt_load=1: cnt_bin <= cnt_load_val; cnt_wrap <= 0. cnt_en and cnt_up are ignored that cycle.
  - cnt_en=1, cnt_up=1: cnt_bin <= cnt_bin + 1, modulo 2**WIDTH. cnt_wrap <= 1 iff the old cnt_bin was all ones.
  - cnt_en=1, cnt_up=0: cnt_bin <= cnt_bin - 1, modulo 2**WIDTH. cnt_wrap <= 1 iff the old cnt_bin was 0.
  - Otherwise: hold; cnt_wrap <= 0.
- cnt_gray is registered from the next binary value on the same edge. cnt_bin and cnt_gray are always mutually consistent, with no extra cycle of lag.
- Latency: 1 cycle from a sampled cnt_en or cnt_load to the updated outputs.
- Invariant: on every cnt_en step (not a load), cnt_gray changes in exactly one bit, including at wrap.
- cnt_gray is a glitch-free flop output, safe to synchronise into another clock domain.
- Converter (independent of the counter; both may be active in the same cycle):
  - Binary->Gray: g[i] = b[i] ^ b[i+1]; g[MSB] = b[MSB].
  - Gray->binary: b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i], as an XOR-prefix chain from the MSB down.
  - conv_valid_out <= conv_valid_in every cycle (latency 1).
  - conv_data_out updates only when conv_valid_in=1; otherwise it holds its last value.
  - There is no backpressure: one result per accepted cycle, with full throughput.
- Width rules: all arithmetic is WIDTH bits with silent modulo wrap. There are no X-propagating paths from an unqualified conv_data_in.

Decomposition:
- Package gray_code_pkg holds:
  - the functions bin2gray and gray2bin, parametrised by width and written as loops;
  - the localparams CONV_B2G=1'b0 and CONV_G2B=1'b1.
- One natural sub-module, gray_conv_stage: the registered converter (valid pipe plus data register), instantiated once.
- The counter path reuses the package function bin2gray directly.

Test Plan:
- Reset then count up, WIDTH=4, RESET_VAL=0, cnt_en=1, cnt_up=1 for 17 cycles:
  - cnt_gray sequence is 0000,0001,0011,0010,0110,...,1000,0000.
  - cnt_wrap pulses exactly on the 15->0 step.
  - Exactly one bit changes per step.
- Count down from 0: after 1 cycle cnt_bin=1111, cnt_gray=1000, cnt_wrap=1. The next step gives 1110/1001 with cnt_wrap=0.
- Load priority: cnt_load=1, cnt_load_val=0110, cnt_en=1, cnt_up=1 in the same cycle. Result is cnt_bin=0110, cnt_gray=0101, cnt_wrap=0.
- Converter sweep, all 16 values in both modes, back-to-back valid:
  - Mode 0: input 1010 gives 1111.
  - Mode 1: input 1111 gives 1010.
  - Results appear exactly 1 cycle later; with conv_valid_in=0 the data holds and conv_valid_out=0.
- Reset mid-operation: assert rst asynchronously between edges while counting at 0111 with a conversion in flight. Outputs go to their reset values immediately. After release, counting restarts from RESET_VAL.
- WIDTH=8, RESET_VAL=8'hFE: one up-step gives cnt_bin=8'hFF, cnt_gray=8'h80, cnt_wrap=0. The next step gives 8'h00, cnt_wrap=1. Gray->binary of 8'h80 gives 8'hFF.
